// File: rtl/exe_stage_fwd.sv
// ---------------------------------------------------------------------------
// exe_stage_fwd
//   Execute stage of a 5-stage pipeline. Resolves RAW hazards by forwarding
//   from the MEM and WB stages, runs the ALU and latches the outcome into the
//   EX/MEM pipeline register.
//
//   Optional feature macro: EXE_MUL_EN
//     defined   : emul=1 starts a radix-2 shift-add multiplier (DW+1 stall
//                 cycles, then one DONE cycle presenting the low DW bits of
//                 the product on ealu).
//     undefined : emul is ignored and stall is tied low.
//
//   ALU control encoding (ealuc):
//     000 add   001 sub   010 and   011 or
//     100 xor   101 sll   110 srl   111 sra
//   Shifts move the B operand by A[SAW-1:0]; with eshift=1 A is
//   sa = zero-extended eimm[SAW+5:6].
//
// Ports
//   clk, clrn                        clock / async active-low clear
//   ea, eb, eimm                     register operands and immediate
//   ealuc, ealuimm, eshift, emul     execute controls
//   exe_rs, exe_rt, exe_d            source / destination register numbers
//   exe_wreg, exe_m2reg, exe_wmem    control bits carried to MEM
//   mem_wregIn, mem_dIn, mem_aluIn   MEM-stage forwarding source
//   wb_wregIn, wb_dIn, wb_aluIn,
//   wb_m2reg, D                      WB-stage forwarding source
//   ealu, z                          combinational result and zero flag
//   stall                            hold upstream stages this cycle
//   mem_wreg, mem_m2reg, mem_wmem,
//   mem_d, S, MEM_Alu                EX/MEM register outputs
// ---------------------------------------------------------------------------
module exe_stage_fwd #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int SAW = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [DW-1:0] ea,
    input  logic [DW-1:0] eb,
    input  logic [DW-1:0] eimm,
    input  logic [2:0]    ealuc,
    input  logic          ealuimm,
    input  logic          eshift,
    input  logic          emul,
    input  logic [RW-1:0] exe_rs,
    input  logic [RW-1:0] exe_rt,
    input  logic [RW-1:0] exe_d,
    input  logic          exe_wreg,
    input  logic          exe_m2reg,
    input  logic          exe_wmem,
    input  logic          mem_wregIn,
    input  logic [RW-1:0] mem_dIn,
    input  logic [DW-1:0] mem_aluIn,
    input  logic          wb_wregIn,
    input  logic [RW-1:0] wb_dIn,
    input  logic [DW-1:0] wb_aluIn,
    input  logic          wb_m2reg,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] ealu,
    output logic          z,
    output logic          stall,
    output logic          mem_wreg,
    output logic          mem_m2reg,
    output logic          mem_wmem,
    output logic [RW-1:0] mem_d,
    output logic [DW-1:0] S,
    output logic [DW-1:0] MEM_Alu
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    logic [DW-1:0]  wb_val;
    logic [DW-1:0]  fa;
    logic [DW-1:0]  fb;
    logic [DW-1:0]  sa;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    logic [SAW-1:0] shamt;
    logic [DW-1:0]  alu_res;

    // A load in WB delivers memory data; anything else delivers its ALU result.
    assign wb_val = wb_m2reg ? D : wb_aluIn;

    // Forwarding: the younger MEM producer wins over WB; r0 is hard-wired zero
    // so a "write" to it must never be forwarded.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fa = ea;
        if (mem_wregIn && (exe_rs != '0) && (exe_rs == mem_dIn))
            fa = mem_aluIn;
        else if (wb_wregIn && (exe_rs != '0) && (exe_rs == wb_dIn))
            fa = wb_val;
    end

    always_comb begin
        fb = eb;
        if (mem_wregIn && (exe_rt != '0) && (exe_rt == mem_dIn))
            fb = mem_aluIn;
        else if (wb_wregIn && (exe_rt != '0) && (exe_rt == wb_dIn))
            fb = wb_val;
    end

    assign sa    = {{(DW-SAW){1'b0}}, eimm[SAW+5:6]};
    assign op_a  = eshift  ? sa   : fa;
    assign op_b  = ealuimm ? eimm : fb;
    assign shamt = op_a[SAW-1:0];

    always_comb begin
        alu_res = '0;
        unique case (ealuc)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLL: alu_res = op_b << shamt;
            ALU_SRL: alu_res = op_b >> shamt;
            ALU_SRA: alu_res = $signed(op_b) >>> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef EXE_MUL_EN
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

    mul_state_t    mul_state;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplr;
    logic [DW-1:0] acc;
    logic [CW-1:0] step;

    // Only the low DW product bits are kept, so the multiplicand can simply
    // shift left and drop its overflow each step.
    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mul_state <= MUL_IDLE;
            mcand     <= '0;
            mplr      <= '0;
            acc       <= '0;
            step      <= '0;
        end else begin
            unique case (mul_state)
                MUL_IDLE: begin
                    if (emul) begin
                        mul_state <= MUL_BUSY;
                        mcand     <= fa;
                        mplr      <= fb;
                        acc       <= '0;
                        step      <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (mplr[0])
                        acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    step  <= step + 1'b1;
                    if (step == CW'(DW-1))
                        mul_state <= MUL_DONE;
                end
                MUL_DONE: mul_state <= MUL_IDLE;
                default:  mul_state <= MUL_IDLE;
            endcase
        end
    end

    // Stall must rise in the very cycle the multiply arrives, hence the
    // combinational emul term while still idle.
    assign stall = ((mul_state == MUL_IDLE) && emul) || (mul_state == MUL_BUSY);
    assign ealu  = (mul_state == MUL_DONE) ? acc : alu_res;
`else
    logic unused_emul;
    assign unused_emul = emul;
    assign stall       = 1'b0;
    assign ealu        = alu_res;
`endif

    assign z = (ealu == '0);

    // EX/MEM register. A stall inserts a bubble by clearing the control bits;
    // the data fields simply hold since the bubble never uses them.
    // NOTE: the async clear resets only these pipeline flops; there is no memory array to reset here.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
            mem_wmem  <= 1'b0;
            mem_d     <= '0;
            S         <= '0;
            MEM_Alu   <= '0;
        end else if (stall) begin
            mem_wreg  <= 1'b0;
            mem_m2reg <= 1'b0;
            mem_wmem  <= 1'b0;
        end else begin
            mem_wreg  <= exe_wreg;
            mem_m2reg <= exe_m2reg;
            mem_wmem  <= exe_wmem;
            mem_d     <= exe_d;
            S         <= fb;
            MEM_Alu   <= ealu;
        end
    end

endmodule

// File: tb/tb_exe_stage_fwd.sv
// ---------------------------------------------------------------------------
// tb_exe_stage_fwd
//   Directed vector table, randomized checks against a reference model, and
//   multi-cycle multiplier / reset sequences when EXE_MUL_EN is defined.
// ---------------------------------------------------------------------------
module tb_exe_stage_fwd;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] ea, eb, eimm;
    logic [2:0]  ealuc;
    logic        ealuimm, eshift, emul;
    logic [4:0]  exe_rs, exe_rt, exe_d;
    logic        exe_wreg, exe_m2reg, exe_wmem;
    logic        mem_wregIn;
    logic [4:0]  mem_dIn;
    logic [31:0] mem_aluIn;
    logic        wb_wregIn;
    logic [4:0]  wb_dIn;
    logic [31:0] wb_aluIn;
    logic        wb_m2reg;
    logic [31:0] D;
    logic [31:0] ealu;
    logic        z, stall;
    logic        mem_wreg, mem_m2reg, mem_wmem;
    logic [4:0]  mem_d;
    logic [31:0] S, MEM_Alu;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    exe_stage_fwd dut (
        .clk(clk), .clrn(clrn),
        .ea(ea), .eb(eb), .eimm(eimm),
        .ealuc(ealuc), .ealuimm(ealuimm), .eshift(eshift), .emul(emul),
        .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_d(exe_d),
        .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
        .mem_wregIn(mem_wregIn), .mem_dIn(mem_dIn), .mem_aluIn(mem_aluIn),
        .wb_wregIn(wb_wregIn), .wb_dIn(wb_dIn), .wb_aluIn(wb_aluIn),
        .wb_m2reg(wb_m2reg), .D(D),
        .ealu(ealu), .z(z), .stall(stall),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
        .mem_d(mem_d), .S(S), .MEM_Alu(MEM_Alu)
    );

    typedef struct {
        logic [4:0]  rs, rt, d;
        logic [31:0] a, b, imm;
        logic [2:0]  aluc;
        logic        aluimm, shift, wreg, m2reg, wmem;
        logic        mw;
        logic [4:0]  md;
        logic [31:0] ma;
        logic        ww;
        logic [4:0]  wd;
        logic [31:0] wa;
        logic        wm2;
        logic [31:0] dd;
        logic [31:0] x_alu;
        logic        x_z;
        logic [31:0] x_s;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        exe_rs = v.rs; exe_rt = v.rt; exe_d = v.d;
        ea = v.a; eb = v.b; eimm = v.imm;
        ealuc = v.aluc; ealuimm = v.aluimm; eshift = v.shift;
        exe_wreg = v.wreg; exe_m2reg = v.m2reg; exe_wmem = v.wmem;
        mem_wregIn = v.mw; mem_dIn = v.md; mem_aluIn = v.ma;
        wb_wregIn = v.ww; wb_dIn = v.wd; wb_aluIn = v.wa;
        wb_m2reg = v.wm2; D = v.dd;
    endtask

    // Reference model: operand selection from the forwarding rules, shifts
    // expressed as multiply/divide by powers of two.
    function automatic logic [31:0] ref_operand(input vec_t v, input logic [4:0] r, input logic [31:0] regval);
        if (r != 0 && v.mw && r == v.md) return v.ma;
        if (r != 0 && v.ww && r == v.wd) return v.wm2 ? v.dd : v.wa;
        return regval;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pow;
        logic [63:0] prod;
        pow = 64'd1 << (a % 32);
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_SLL: begin
                prod = {32'd0, b} * pow;
                return prod[31:0];
            end
            OP_SRL: return b / pow[31:0];
            default: return b[31] ? ~((~b) / pow[31:0]) : b / pow[31:0];
        endcase
    endfunction

    task automatic ref_model(input vec_t v, output logic [31:0] r, output logic [31:0] s);
        logic [31:0] a, b, fa, fb;
        fa = ref_operand(v, v.rs, v.a);
        fb = ref_operand(v, v.rt, v.b);
        a  = v.shift  ? {27'd0, v.imm[10:6]} : fa;
        b  = v.aluimm ? v.imm : fb;
        r  = ref_alu(v.aluc, a, b);
        s  = fb;
    endtask

    task automatic check_regs(input string tag, input vec_t v, input logic [31:0] x_alu, input logic [31:0] x_s);
        check({tag, " MEM_Alu"}, MEM_Alu, x_alu);
        check({tag, " S"}, S, x_s);
        check({tag, " mem_d"}, mem_d, v.d);
        check({tag, " mem_wreg"}, mem_wreg, v.wreg);
        check({tag, " mem_m2reg"}, mem_m2reg, v.m2reg);
        check({tag, " mem_wmem"}, mem_wmem, v.wmem);
    endtask

`ifdef EXE_MUL_EN
    // Steps through a stalled multiply; called at a negedge with emul=1 applied.
    task automatic wait_mul(input logic [4:0] held_d, output int stalls);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) break;
            stalls++;
            @(posedge clk);
            #1;
            check("bubble mem_wreg", mem_wreg, 0);
            check("bubble mem_wmem", mem_wmem, 0);
            check("hold mem_d", mem_d, held_d);
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [31:0] x_alu, x_s;
        int stalls;

        //          rs rt  d  a            b              imm       aluc    im sh wr m2 wm mw md ma        ww wd wa         wm2 dd         x_alu           x_z x_s
        vecs[0]  = '{1, 2, 3, 5,           7,             0,        OP_ADD, 0, 0, 1, 0, 0, 0, 0, 0,        0, 0, 0,         0,  0,         12,             0,  7};
        vecs[1]  = '{4, 1, 4, 100,         0,             0,        OP_ADD, 0, 0, 1, 0, 0, 1, 4, 9,        1, 4, 1,         0,  0,         9,              0,  0};
        vecs[2]  = '{1, 0, 2, 0,           0,             0,        OP_ADD, 0, 0, 1, 0, 0, 1, 0, 'hFF,     0, 0, 0,         0,  0,         0,              1,  0};
        vecs[3]  = '{1, 6, 0, 'h100,       'h55,          'h10,     OP_ADD, 1, 0, 0, 0, 1, 0, 0, 0,        1, 6, 'h1234,    1,  'hABCD,    'h110,          0,  'hABCD};
        vecs[4]  = '{1, 2, 8, 3,           5,             0,        OP_SUB, 0, 0, 1, 0, 0, 0, 0, 0,        0, 0, 0,         0,  0,         'hFFFF_FFFE,    0,  5};
        vecs[5]  = '{1, 2, 8, 9,           9,             0,        OP_SUB, 0, 0, 1, 0, 0, 0, 0, 0,        0, 0, 0,         0,  0,         0,              1,  9};
        vecs[6]  = '{2, 1, 9, 7,           3,             'hF93F,   OP_SLL, 0, 1, 1, 0, 0, 1, 2, 'h1F,     0, 0, 0,         0,  0,         'h30,           0,  3};
        vecs[7]  = '{0, 1, 9, 0,           'h8000_0000,   'hF93F,   OP_SRA, 0, 1, 1, 0, 0, 0, 0, 0,        0, 0, 0,         0,  0,         'hF800_0000,    0,  'h8000_0000};
        vecs[8]  = '{0, 1, 9, 0,           'h8000_0000,   'hF93F,   OP_SRL, 0, 1, 1, 0, 0, 0, 0, 0,        0, 0, 0,         0,  0,         'h0800_0000,    0,  'h8000_0000};
        vecs[9]  = '{3, 1, 10, 0,          1,             0,        OP_OR,  0, 0, 1, 0, 0, 0, 0, 0,        1, 3, 'h20,      0,  'h77,      'h21,           0,  1};
        vecs[10] = '{5, 5, 11, 1,          2,             0,        OP_XOR, 0, 0, 1, 1, 0, 1, 5, 'hF0F0,   1, 5, 'h1111,    0,  0,         0,              1,  'hF0F0};
        vecs[11] = '{2, 3, 12, 'h11,       'h22,          0,        OP_ADD, 0, 0, 1, 0, 0, 0, 0, 0,        0, 2, 'h99,      0,  0,         'h33,           0,  'h22};
        vecs[12] = '{1, 4, 13, 'hFF,       0,             0,        OP_AND, 0, 0, 1, 0, 0, 0, 0, 0,        1, 4, 0,         1,  'h0F0F,    'h0F,           0,  'h0F0F};

        emul = 1'b0;
        apply('{default: 0});
        clrn = 1'b1;
        #1 clrn = 1'b0;
        #2;
        check("reset mem_wreg", mem_wreg, 0);
        check("reset mem_m2reg", mem_m2reg, 0);
        check("reset mem_wmem", mem_wmem, 0);
        check("reset mem_d", mem_d, 0);
        check("reset S", S, 0);
        check("reset MEM_Alu", MEM_Alu, 0);
        check("reset stall", stall, 0);
        @(negedge clk);
        clrn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d ealu", i), ealu, vecs[i].x_alu);
            check($sformatf("vec%0d z", i), z, vecs[i].x_z);
            check($sformatf("vec%0d stall", i), stall, 0);
            @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d", i), vecs[i], vecs[i].x_alu, vecs[i].x_s);
        end

        // Mid-stream clear: registered outputs were non-zero after the last vector.
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("clear MEM_Alu", MEM_Alu, 0);
        check("clear S", S, 0);
        check("clear mem_d", mem_d, 0);
        check("clear mem_wreg", mem_wreg, 0);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v = '{default: 0};
            v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
            v.d  = 5'($urandom_range(0, 31));
            v.a  = $urandom; v.b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            v.imm = $urandom;
            v.aluc = 3'($urandom_range(0, 7));
            v.aluimm = ($urandom_range(0, 3) == 0); v.shift = ($urandom_range(0, 3) == 0);
            v.wreg = 1'($urandom); v.m2reg = 1'($urandom); v.wmem = 1'($urandom);
            v.mw = 1'($urandom); v.md = 5'($urandom_range(0, 3)); v.ma = $urandom;
            v.ww = 1'($urandom); v.wd = 5'($urandom_range(0, 3)); v.wa = $urandom;
            v.wm2 = 1'($urandom); v.dd = $urandom;
            apply(v);
            ref_model(v, x_alu, x_s);
            #1;
            check("rand ealu", ealu, x_alu);
            check("rand z", z, (x_alu == 0));
            @(posedge clk);
            #1;
            check_regs("rand", v, x_alu, x_s);
        end

`ifdef EXE_MUL_EN
        // Plain op first so mem_d has a known value to hold through the stall.
        @(negedge clk);
        apply(vecs[0]);
        exe_d = 5;
        @(posedge clk);
        #1;
        check("pre-mul mem_d", mem_d, 5);

        @(negedge clk);
        v = '{default: 0};
        v.rs = 1; v.rt = 2; v.d = 7; v.wreg = 1;
        v.a = 32'hFFFF_FFFF; v.b = 3;
        apply(v);
        emul = 1'b1;
        wait_mul(5'd5, stalls);
        check("mul stall cycles", stalls, 33);
        check("mul done ealu", ealu, 32'hFFFF_FFFD);
        check("mul done z", z, 0);
        @(posedge clk);
        #1;
        check("mul MEM_Alu", MEM_Alu, 32'hFFFF_FFFD);
        check("mul mem_d", mem_d, 7);
        check("mul mem_wreg", mem_wreg, 1);

        // Multiply with A forwarded from MEM, aborted by a reset in BUSY cycle 10.
        @(negedge clk);
        v = '{default: 0};
        v.rs = 2; v.rt = 3; v.d = 9; v.wreg = 1;
        v.a = 0; v.b = 7; v.mw = 1; v.md = 2; v.ma = 6;
        apply(v);
        emul = 1'b1;
        for (int i = 0; i < 11; i++) @(posedge clk);
        @(negedge clk);
        clrn = 1'b0;
        emul = 1'b0;
        #1;
        check("abort stall", stall, 0);
        check("abort mem_wreg", mem_wreg, 0);
        check("abort MEM_Alu", MEM_Alu, 0);
        check("abort mem_d", mem_d, 0);
        check("abort S", S, 0);
        @(negedge clk);
        clrn = 1'b1;
        emul = 1'b1;
        wait_mul(5'd0, stalls);
        check("mul2 stall cycles", stalls, 33);
        check("mul2 done ealu", ealu, 42);
        @(posedge clk);
        #1;
        check("mul2 MEM_Alu", MEM_Alu, 42);
        check("mul2 mem_d", mem_d, 9);
        check("mul2 S", S, 7);
        @(negedge clk);
        emul = 1'b0;
`else
        // Without the multiplier, emul must not stall or change the result.
        @(negedge clk);
        apply(vecs[0]);
        emul = 1'b1;
        #1;
        check("emul ignored stall", stall, 0);
        check("emul ignored ealu", ealu, 12);
        @(posedge clk);
        #1;
        check("emul ignored MEM_Alu", MEM_Alu, 12);
        check("emul ignored mem_wreg", mem_wreg, 1);
        @(negedge clk);
        emul = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
